// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - round-robin arbiter driving a shared 2-to-4 decoder bank
//
// Four level-sensitive requesters share one decoder output bank. An idle arbiter
// searches upward from a rotating pointer and grants the first requester it finds.
// The owner keeps the grant for as long as it holds its request. After a release the
// arbiter always spends one IDLE cycle before it can grant again.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant is forcibly released after MAX_HOLD cycles and timeout pulses.
//   When undefined, a grant is held indefinitely and timeout is tied low.
//
// Parameters:
//   MAX_HOLD    - number of BUSY cycles per grant before forced release (>= 2)
//   CNT_W       - hold counter width, 2**CNT_W > MAX_HOLD
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous, active-high
//   req[3:0]    - level request per requester
//   grant[3:0]  - registered one-hot grant, zero when no owner
//   grant_addr  - encoded owner index (decoder address), kept after release
//   grant_valid - decoder enable, high iff grant != 0
//   timeout     - one-cycle pulse on forced release
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_addr,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       win;

    // Search from ptr upward; the 2-bit index wraps 3 -> 0 naturally.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= 4'b0000;
            grant_addr  <= 2'd0;
            grant_valid <= 1'b0;
            ptr         <= 2'd0;
            hold_cnt    <= '0;
            state       <= IDLE;
`ifdef ARB_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant       <= 4'b0001 << win;
                        grant_addr  <= win;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // A voluntary release wins over a forced one on the same cycle,
                    // so timeout stays low in that case.
                    if (!req[grant_addr]) begin
                        grant       <= 4'b0000;
                        grant_valid <= 1'b0;
                        ptr         <= grant_addr + 2'd1;
                        state       <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        grant       <= 4'b0000;
                        grant_valid <= 1'b0;
                        ptr         <= grant_addr + 2'd1;
                        state       <= IDLE;
                        timeout     <= 1'b1;
                    end
`endif
                    else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - scoreboard bench for rr_decoder_arbiter
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_addr;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int n_vec = 0;

    typedef struct {
        int         id;
        logic [3:0] g;
        logic [1:0] a;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];

    rr_decoder_arbiter #(
        .MAX_HOLD(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .grant_addr(grant_addr),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", nm, id, act, want);
        end
    endtask

    // Monitor: the registered outputs settle after each rising edge; compare then.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", e.id, int'(grant), int'(e.g));
                chk("grant_addr", e.id, int'(grant_addr), int'(e.a));
                chk("grant_valid", e.id, int'(grant_valid), int'(e.v));
                chk("timeout", e.id, int'(timeout), int'(e.t));
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] a, input logic t);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        e.id  = n_vec;
        e.g   = g;
        e.a   = a;
        e.v   = (g != 4'b0000);
        e.t   = t;
        exp_q.push_back(e);
        n_vec++;
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] gn;
        logic [1:0] k2;

        // 1: reset with all requesting, then first grant goes to requester 0
        step(1, 4'b1111, 4'b0000, 2'd0, 0);
        step(1, 4'b1111, 4'b0000, 2'd0, 0);
        step(0, 4'b1111, 4'b0001, 2'd0, 0);

        // 2: rotation, each owner holds 3 cycles then drops for one cycle
        for (int k = 0; k < 4; k++) begin
            k2 = 2'(k);
            g  = 4'b0001 << k2;
            gn = 4'b0001 << (k2 + 2'd1);
            step(0, 4'b1111, g, k2, 0);
            step(0, 4'b1111, g, k2, 0);
            step(0, 4'b1111 & ~g, 4'b0000, k2, 0);
            step(0, 4'b1111, gn, k2 + 2'd1, 0);
        end
        step(0, 4'b1110, 4'b0000, 2'd0, 0);          // ptr -> 1

        // 3: wrap, owner 3 releases while only requester 0 asks
        step(0, 4'b1000, 4'b1000, 2'd3, 0);
        step(0, 4'b0001, 4'b0000, 2'd3, 0);          // release, ptr 3 -> 0
        step(0, 4'b0001, 4'b0001, 2'd0, 0);
        step(0, 4'b0000, 4'b0000, 2'd0, 0);          // ptr -> 1

        // 4: non-preemption, owner 1 keeps the bank while 0 and 2 request
        step(0, 4'b0010, 4'b0010, 2'd1, 0);
        step(0, 4'b0111, 4'b0010, 2'd1, 0);
        step(0, 4'b0111, 4'b0010, 2'd1, 0);
        step(0, 4'b0101, 4'b0000, 2'd1, 0);          // ptr -> 2
        step(0, 4'b0101, 4'b0100, 2'd2, 0);          // 2 beats 0
        step(0, 4'b0000, 4'b0000, 2'd2, 0);          // ptr -> 3

        // 5: requester 2 holds its request continuously
        step(0, 4'b0100, 4'b0100, 2'd2, 0);
`ifdef ARB_TIMEOUT_EN
        step(0, 4'b0100, 4'b0100, 2'd2, 0);
        step(0, 4'b0100, 4'b0100, 2'd2, 0);
        step(0, 4'b0100, 4'b0100, 2'd2, 0);          // 4th grant cycle
        step(0, 4'b0100, 4'b0000, 2'd2, 1);          // forced release
        step(0, 4'b0100, 4'b0100, 2'd2, 0);          // sole requester re-granted
        step(0, 4'b0100, 4'b0100, 2'd2, 0);
        step(0, 4'b0100, 4'b0100, 2'd2, 0);
        step(0, 4'b0100, 4'b0100, 2'd2, 0);
        step(0, 4'b0000, 4'b0000, 2'd2, 0);          // drop on the timeout cycle
`else
        for (int i = 0; i < 99; i++) step(0, 4'b0100, 4'b0100, 2'd2, 0);
        step(0, 4'b0000, 4'b0000, 2'd2, 0);
`endif
        // ptr -> 3 in either build

        // 6: reset two cycles into a grant to requester 3
        step(0, 4'b1000, 4'b1000, 2'd3, 0);
        step(0, 4'b1000, 4'b1000, 2'd3, 0);
        step(1, 4'b1000, 4'b0000, 2'd0, 0);
        step(0, 4'b1010, 4'b0010, 2'd1, 0);          // ptr back at 0
        step(0, 4'b0000, 4'b0000, 2'd1, 0);
        step(0, 4'b0000, 4'b0000, 2'd1, 0);          // idle with no requests

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
